half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder.sv | 90 +++++++++
 tb/tb_half_adder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//
// WIDTH independent 1-bit half adders with one registered output stage.
// Bit i produces sum[i] = a[i] ^ b[i] and carry[i] = a[i] & b[i]. No carry
// moves between bit positions, so this is not a WIDTH-bit ripple adder.
// Because of that, {carry, 1'b0} + sum always equals a + b.
//
// Operands are captured on a rising edge when in_valid is high. The results
// appear after that edge, and out_valid is high for exactly one cycle. When
// in_valid is low, all result registers keep their values, so unknown
// operands at that time cannot reach the outputs. There is no backpressure:
// every valid pair is accepted and replaces the previous result.
//
// Ports
//   clk        rising-edge clock for all registers
//   rst        asynchronous active-high reset; clears every output
//   in_valid   qualifies a/b for capture on the current edge
//   a, b       operands, WIDTH bits; a[i] pairs with b[i]
//   sum        registered per-bit sum
//   carry      registered per-bit carry
//   out_valid  one-cycle pulse per captured operand pair
//   carry_cnt  registered population count of carry (0..WIDTH)
//   carry_any  registered OR-reduction of carry
// -----------------------------------------------------------------------------
module half_adder #(
  parameter int unsigned WIDTH = 4  // legal range 1..32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic [WIDTH-1:0]             sum,
  output logic [WIDTH-1:0]             carry,
  output logic                         out_valid,
  output logic [$clog2(WIDTH+1)-1:0]   carry_cnt,
  output logic                         carry_any
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sum_d,   sum_q;
  logic [WIDTH-1:0] carry_d, carry_q;
  logic [CntW-1:0]  cnt_d,   cnt_q;
  logic             any_d,   any_q;
  logic             valid_q;

  // Next-state logic. The count and the OR are derived from the new carry
  // vector in the same cycle, so they always agree with the registered carry.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    any_d   = any_q;
    if (in_valid) begin
      sum_d   = a ^ b;
      carry_d = a & b;
      cnt_d   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_d = cnt_d + CntW'(carry_d[i]);
      end
      any_d = |carry_d;
    end
  end

  // Reset also wipes a result that was captured on the edge just before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      any_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      any_q   <= any_d;
      valid_q <= in_valid;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign carry_cnt = cnt_q;
  assign carry_any = any_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid;

  // WIDTH=4 instance
  logic [3:0]  a4, b4, sum4, carry4;
  logic [2:0]  cnt4;
  logic        ov4, any4;
  // WIDTH=1 instance
  logic [0:0]  a1, b1, sum1, carry1;
  logic [0:0]  cnt1;
  logic        ov1, any1;
  // WIDTH=32 instance
  logic [31:0] a32, b32, sum32, carry32;
  logic [5:0]  cnt32;
  logic        ov32, any32;

  half_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .sum(sum4), .carry(carry4), .out_valid(ov4), .carry_cnt(cnt4), .carry_any(any4)
  );
  half_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .sum(sum1), .carry(carry1), .out_valid(ov1), .carry_cnt(cnt1), .carry_any(any1)
  );
  half_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a32), .b(b32),
    .sum(sum32), .carry(carry32), .out_valid(ov32), .carry_cnt(cnt32), .carry_any(any32)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic [31:0] carry;
    int unsigned cnt;
    logic        any;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q32[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference behaviour of a w-bit bank of half adders.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int unsigned w);
    exp_t        e;
    logic [31:0] m;
    m       = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    e.a     = a & m;
    e.b     = b & m;
    e.sum   = (a ^ b) & m;
    e.carry = (a & b) & m;
    e.cnt   = 0;
    for (int i = 0; i < 32; i++) e.cnt += int'(e.carry[i]);
    e.any   = (e.cnt != 0);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1; a32 = '1; b32 = '1;
    #1;
    n_vec++;
    if ({ov4, sum4, carry4, cnt4, any4} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_async: got %b required 0", {ov4, sum4, carry4, cnt4, any4});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({ov4, sum4, carry4, cnt4, any4, ov32, carry32} !== 46'd0) begin
      n_err++;
      $display("FAIL reset_discard: got %b required 0", {ov4, sum4, carry4, cnt4, any4});
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({ov4, sum4, carry4, cnt4, any4} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_release: got %b required 0", {ov4, sum4, carry4, cnt4, any4});
    end
  endtask

  // Runs back-to-back as well: in_valid stays high across all 256 edges.
  task automatic test_exhaustive();
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      {a4, b4} = i[7:0];
      q4.push_back(model(32'(a4), 32'(b4), 4));
      @(posedge clk); #1;
      e = q4.pop_front();
      n_vec++;
      if ({ov4, sum4, carry4, cnt4, any4} !==
          {1'b1, e.sum[3:0], e.carry[3:0], 3'(e.cnt), e.any}) begin
        n_err++;
        $display("FAIL exhaustive a=%h b=%h: got ov=%b s=%b c=%b n=%0d any=%b required s=%b c=%b n=%0d any=%b",
                 e.a[3:0], e.b[3:0], ov4, sum4, carry4, cnt4, any4,
                 e.sum[3:0], e.carry[3:0], e.cnt, e.any);
      end
    end
  endtask

  task automatic test_corners();
    logic [3:0] ta [2];
    logic [3:0] tb [2];
    logic [12:0] req [2];
    ta[0] = 4'b1111; tb[0] = 4'b1111; req[0] = {1'b1, 4'b0000, 4'b1111, 3'd4, 1'b1};
    ta[1] = 4'b1010; tb[1] = 4'b0101; req[1] = {1'b1, 4'b1111, 4'b0000, 3'd0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a4 = ta[i]; b4 = tb[i];
      @(posedge clk); #1;
      n_vec++;
      if ({ov4, sum4, carry4, cnt4, any4} !== req[i]) begin
        n_err++;
        $display("FAIL corner%0d: got %b required %b", i, {ov4, sum4, carry4, cnt4, any4}, req[i]);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; a4 = 4'b0011; b4 = 4'b0110;
    q4.push_back(model(32'(a4), 32'(b4), 4));
    @(posedge clk); #1;
    e = q4.pop_front();
    n_vec++;
    if ({ov4, sum4, carry4} !== {1'b1, 4'b0101, 4'b0010}) begin
      n_err++;
      $display("FAIL hold_capture: got ov=%b s=%b c=%b required ov=1 s=0101 c=0010",
               ov4, sum4, carry4);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 2) begin
        a4 = 4'bx0z1; b4 = 4'bzx10;
      end else begin
        a4 = 4'($urandom()); b4 = 4'($urandom());
      end
      @(posedge clk); #1;
      n_vec++;
      if ({ov4, sum4, carry4, cnt4, any4} !==
          {1'b0, e.sum[3:0], e.carry[3:0], 3'(e.cnt), e.any}) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got ov=%b s=%b c=%b n=%0d any=%b required ov=0 s=%b c=%b",
                 k, ov4, sum4, carry4, cnt4, any4, e.sum[3:0], e.carry[3:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; a4 = 4'b1111; b4 = 4'b1011;
    q4.push_back(model(32'(a4), 32'(b4), 4));
    @(posedge clk); #1;
    e = q4.pop_front();
    n_vec++;
    if ({ov4, sum4, carry4, cnt4, any4} !==
        {1'b1, e.sum[3:0], e.carry[3:0], 3'(e.cnt), e.any}) begin
      n_err++;
      $display("FAIL areset_capture: got s=%b c=%b required s=%b c=%b",
               sum4, carry4, e.sum[3:0], e.carry[3:0]);
    end
    // Mid-cycle, well before the next edge.
    #2; rst = 1'b1; in_valid = 1'b0;
    #1;
    n_vec++;
    if ({ov4, sum4, carry4, cnt4, any4} !== 13'd0) begin
      n_err++;
      $display("FAIL areset_clear: got %b required 0", {ov4, sum4, carry4, cnt4, any4});
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; a4 = 4'b0001; b4 = 4'b0001;
    @(posedge clk); #1;
    n_vec++;
    if ({ov4, sum4, carry4, cnt4, any4} !== {1'b1, 4'b0000, 4'b0001, 3'd1, 1'b1}) begin
      n_err++;
      $display("FAIL areset_recapture: got ov=%b s=%b c=%b n=%0d required ov=1 s=0000 c=0001 n=1",
               ov4, sum4, carry4, cnt4);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          pulses;
    logic [31:0] lhs;
    pulses = 0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        in_valid = 1'b1; a4 = 4'($urandom()); b4 = 4'($urandom());
        q4.push_back(model(32'(a4), 32'(b4), 4));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (ov4 === 1'b1 && q4.size() != 0) begin
        pulses++;
        e   = q4.pop_front();
        lhs = (32'(carry4) << 1) + 32'(sum4);
        n_vec++;
        if (lhs !== e.a + e.b || sum4 !== e.sum[3:0] || carry4 !== e.carry[3:0]) begin
          n_err++;
          $display("FAIL stream_pair%0d: got {c,0}+s=%0d s=%b c=%b required %0d s=%b c=%b",
                   pulses, lhs, sum4, carry4, e.a + e.b, e.sum[3:0], e.carry[3:0]);
        end
      end
    end
    // One idle edge: no further pulse may appear.
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    if (ov4 === 1'b1) pulses++;
    n_vec++;
    if (pulses != 8 || q4.size() != 0) begin
      n_err++;
      $display("FAIL stream_count: got %0d pulses (%0d unmatched) required 8",
               pulses, q4.size());
    end
  endtask

  task automatic test_width_sweep();
    exp_t        e1, e32;
    int unsigned max1, max32;
    max1 = 0; max32 = 0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      if (k < 4) {a1, b1} = k[1:0];
      else       {a1, b1} = 2'($urandom());
      if (k == 0)      begin a32 = '1; b32 = '1; end
      else if (k == 1) begin a32 = '0; b32 = '1; end
      else if (k == 2) begin a32 = 32'hAAAA_AAAA; b32 = 32'h5555_5555; end
      else             begin a32 = $urandom(); b32 = $urandom(); end
      q1.push_back(model(32'(a1), 32'(b1), 1));
      q32.push_back(model(a32, b32, 32));
      @(posedge clk); #1;
      e1  = q1.pop_front();
      e32 = q32.pop_front();
      if (int'(cnt1) > int'(max1))   max1  = cnt1;
      if (int'(cnt32) > int'(max32)) max32 = cnt32;
      n_vec++;
      if ({ov1, sum1, carry1, cnt1, any1} !== {1'b1, e1.sum[0], e1.carry[0], 1'(e1.cnt), e1.any}) begin
        n_err++;
        $display("FAIL w1 a=%b b=%b: got s=%b c=%b n=%0d any=%b required s=%b c=%b n=%0d",
                 e1.a[0], e1.b[0], sum1, carry1, cnt1, any1, e1.sum[0], e1.carry[0], e1.cnt);
      end
      n_vec++;
      if ({ov32, sum32, carry32, cnt32, any32} !== {1'b1, e32.sum, e32.carry, 6'(e32.cnt), e32.any}) begin
        n_err++;
        $display("FAIL w32 a=%h b=%h: got s=%h c=%h n=%0d any=%b required s=%h c=%h n=%0d any=%b",
                 e32.a, e32.b, sum32, carry32, cnt32, any32, e32.sum, e32.carry, e32.cnt, e32.any);
      end
    end
    n_vec++;
    if (max1 != 1 || max32 != 32) begin
      n_err++;
      $display("FAIL width_range: got max w1=%0d w32=%0d required 1 and 32", max1, max32);
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_corners();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_width_sweep();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test required completion");
    $fatal(1, "timeout");
  end

endmodule
